uart_tx: RTL and testbench

//   UART transmitter: 8 data bits, LSB first, 1 stop bit, optional parity, configurable baud.

---
 rtl/uart_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter (8N1, or 8E1/8O1 when UART_TX_PARITY_EN is defined) with a valid/ready TX FIFO.
// The FIFO head is read through a register, so a byte starts on the second edge after acceptance.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 51000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    // Elaboration-time sanity checks on the configuration.
    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD > 1) begin : gen_param_err
        $error("uart_tx: illegal parameter combination");
    end

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       head_q;
    logic             head_vld_q;
    logic             push;
    logic             pop;

    assign o_ready    = (cnt_q != FULL_CNT);
    assign push       = i_valid && o_ready;
    assign o_fifo_cnt = cnt_q;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // Head view is invalidated on a pop and refreshed from the new read pointer next cycle.
            head_q     <= mem_q[rd_ptr_q];
            head_vld_q <= (cnt_q != '0) && !pop;
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign bit_done = (baud_cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (head_vld_q) begin
                    pop        = 1'b1;
                    shift_d    = head_q;
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = StStart;
                    tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^head_q) ^ 1'(PARITY_ODD);
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    state_d    = StData;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    state_d    = StStop;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (head_vld_q) begin
                        pop       = 1'b1;
                        shift_d   = head_q;
                        bit_idx_d = '0;
                        state_d   = StStart;
                        tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d     = (^head_q) ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (cnt_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: CLKS_PER_BIT=10, FIFO_DEPTH=4.
// Defining UART_TX_PARITY_EN also builds an odd-parity instance and runs the parity test.
module tb_uart_tx;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int          CPB      = 10;
    localparam int          PERIOD   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
`else
    localparam int          NBITS    = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;

    int checks;
    int errors;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_fifo_cnt (cnt)
    );

`ifdef UART_TX_PARITY_EN
    logic       ready_odd;
    logic       tx_odd;
    logic       busy_odd;
    logic [2:0] cnt_odd;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4),
        .PARITY_ODD (1)
    ) u_dut_odd (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready_odd),
        .o_tx       (tx_odd),
        .o_busy     (busy_odd),
        .o_fifo_cnt (cnt_odd)
    );
`endif

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Expected line level for frame bit k (0 = start).
    function automatic logic exp_bit(input logic [7:0] b, input int k, input logic odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NBITS == 11) return (^b) ^ odd;
        return 1'b1;
    endfunction

    // Loopback receiver: waits for a start bit, then samples at mid-bit.
    task automatic rx_frame(output logic [7:0] b, output logic p, output bit ok,
                            output time t_fall);
        bit found;
        found  = 1'b0;
        b      = '0;
        p      = 1'b0;
        ok     = 1'b0;
        t_fall = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (found) begin
            t_fall = $time;
            ok     = 1'b1;
            repeat (CPB / 2) tick();
            if (tx !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) tick();
                b[k] = tx;
            end
            if (NBITS == 11) begin
                repeat (CPB) tick();
                p = tx;
            end
            repeat (CPB) tick();
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        valid = 1'b0;
        data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx: got %b want 1", tx);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'h55;
        do_reset();
        push_byte(b);
        tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL single_latency_early: tx got %b want 1 one edge after accept", tx);
        end
        tick();
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i > 0) tick();
            checks++;
            if (tx !== exp_bit(b, i / CPB, 1'b0)) begin
                errors++;
                $display("FAIL single_wave cycle %0d: tx got %b want %b", i, tx,
                         exp_bit(b, i / CPB, 1'b0));
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_last: got %b want 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL single_idle: busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        logic [7:0] b;
        logic       p;
        bit         ok;
        time        t_fall;
        time        t_prev;
        exp[0] = 8'hA5;
        exp[1] = 8'h3C;
        exp[2] = 8'hFF;
        do_reset();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = exp[i];
            tick();
        end
        valid  = 1'b0;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            rx_frame(b, p, ok, t_fall);
            checks++;
            if (!ok || b !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h ok=%0d want %h ok=1", i, b, ok, exp[i]);
            end
            if (NBITS == 11) begin
                checks++;
                if (p !== ^exp[i]) begin
                    errors++; $display("FAIL b2b_parity%0d: got %b want %b", i, p, ^exp[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (t_fall - t_prev != time'(NBITS * CPB * PERIOD)) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got %0t want %0d", i, t_fall - t_prev,
                             NBITS * CPB * PERIOD);
                end
            end
            t_prev = t_fall;
        end
        repeat (CPB) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] vals [7];
        logic [7:0] b;
        logic       p;
        bit         ok;
        bit         acc;
        time        t_fall;
        int         idx;
        vals[0] = 8'h81; vals[1] = 8'h42; vals[2] = 8'hC3; vals[3] = 8'h24;
        vals[4] = 8'hE7; vals[5] = 8'h18; vals[6] = 8'h99;
        do_reset();
        push_byte(8'h5A);
        tick();
        tick();
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("FAIL full_first_start: tx got %b want 0", tx);
        end
        idx = 0;
        for (int c = 0; c < CPB; c++) begin
            data  = vals[idx];
            valid = (idx < 7);
            acc   = ready && valid;
            tick();
            if (acc) idx++;
        end
        valid = 1'b0;
        checks++;
        if (idx != 4) begin
            errors++; $display("FAIL full_accepted: got %0d want 4", idx);
        end
        checks++;
        if (ready !== 1'b0 || cnt !== 3'd4) begin
            errors++; $display("FAIL full_flags: ready=%b cnt=%0d want ready=0 cnt=4", ready, cnt);
        end
        repeat (NBITS * CPB - 1 - CPB) tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL full_first_stop: tx got %b want 1", tx);
        end
        for (int i = 0; i < 4; i++) begin
            rx_frame(b, p, ok, t_fall);
            checks++;
            if (!ok || b !== vals[i]) begin
                errors++;
                $display("FAIL full_byte%0d: got %h ok=%0d want %h ok=1", i, b, ok, vals[i]);
            end
        end
        repeat (3 * CPB) tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL full_drained: busy=%b tx=%b cnt=%0d want 0 1 0", busy, tx, cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit low_seen;
        do_reset();
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h96);
        checks++;
        if (tx !== 1'b0 || cnt !== 3'd2) begin
            errors++; $display("FAIL rstmid_setup: tx=%b cnt=%0d want 0 2", tx, cnt);
        end
        repeat (44) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL rstmid_tx: got %b want 1", tx);
        end
        checks++;
        if (cnt !== 3'd0 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_flags: cnt=%0d busy=%b ready=%b want 0 0 1", cnt, busy, ready);
        end
        rst_n    = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 3 * NBITS * CPB; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        checks++;
        if (low_seen) begin
            errors++; $display("FAIL rstmid_quiet: activity seen after reset, want none");
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        push_byte(8'h07);
        tick();
        tick();
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i > 0) tick();
            checks++;
            if (tx !== exp_bit(8'h07, i / CPB, 1'b0) ||
                tx_odd !== exp_bit(8'h07, i / CPB, 1'b1)) begin
                errors++;
                $display("FAIL parity_wave cycle %0d: even=%b odd=%b", i, tx, tx_odd);
            end
            if (i == 9 * CPB + CPB / 2) begin
                checks++;
                if (tx !== 1'b1 || tx_odd !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_bit: even=%b odd=%b want 1 0", tx, tx_odd);
                end
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || busy_odd !== 1'b0) begin
            errors++; $display("FAIL parity_len: busy=%b busy_odd=%b want 0 0", busy, busy_odd);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
